// File: rtl/mult_seq_nbit.sv
// ============================================================================
//  Module      : mult_seq_nbit
//  Description : Parametrised sequential shift-add multiplier with
//                signed/unsigned mode, valid/ready handshakes on both sides
//                and a WIDTH-bit overflow flag. One partial product per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_seq_nbit #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 overflow
);

    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_mag_a;
    logic [WIDTH-1:0]     r_mag_b;
    logic                 r_neg;
    logic                 r_sgn;
    logic [c_CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_overflow;
    logic                 r_in_ready;
    logic                 r_out_valid;

    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_prod_next;
    logic                 w_ovf_next;

    // Operand magnitudes; the most negative value maps to 2^(W-1), which
    // still fits as an unsigned WIDTH-bit magnitude.
    always_comb begin
        w_abs_a = (is_signed && a[WIDTH-1]) ? ((~a) + WIDTH'(1)) : a;
        w_abs_b = (is_signed && b[WIDTH-1]) ? ((~b) + WIDTH'(1)) : b;
    end

    // Partial-product step and final sign/overflow resolution.
    always_comb begin
        w_addend    = r_mag_b[r_count] ? ({{WIDTH{1'b0}}, r_mag_a} << r_count)
                                       : '0;
        w_acc_next  = r_acc + w_addend;
        w_prod_next = r_neg ? ((~w_acc_next) + (2*WIDTH)'(1)) : w_acc_next;
        if (r_sgn)
            w_ovf_next = (w_prod_next[2*WIDTH-1:WIDTH] != {WIDTH{w_prod_next[WIDTH-1]}});
        else
            w_ovf_next = (w_prod_next[2*WIDTH-1:WIDTH] != '0);
    end

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_mag_a     <= '0;
            r_mag_b     <= '0;
            r_neg       <= 1'b0;
            r_sgn       <= 1'b0;
            r_count     <= '0;
            r_acc       <= '0;
            r_product   <= '0;
            r_overflow  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mag_a    <= w_abs_a;
                        r_mag_b    <= w_abs_b;
                        r_neg      <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_sgn      <= is_signed;
                        r_count    <= '0;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + c_CNT_ONE;
                    if (r_count == c_CNT_LAST) begin
                        r_product   <= w_prod_next;
                        r_overflow  <= w_ovf_next;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_product;
    assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_mult_seq_nbit.sv
// ============================================================================
//  Module      : tb_mult_seq_nbit
//  Description : Directed self-checking bench for mult_seq_nbit (WIDTH=16)
//                plus a seeded random sweep against a wide-integer model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_seq_nbit;

    localparam int WIDTH = 16;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              is_signed;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       product;
    logic              overflow;

    int errors = 0;
    int checks = 0;

    mult_seq_nbit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one operation; lat is edges from accept to out_valid (0 if never accepted).
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                          input int pre, input int stall,
                          output logic [31:0] p, output logic o, output int lat);
        int n;
        lat = 0;
        p   = '0;
        o   = 1'b0;
        repeat (pre) @(posedge clk);
        #1;
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_v;
        is_signed = ts;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        a         = ~ta;
        b         = 16'h1234;
        is_signed = ~ts;
        do begin
            @(posedge clk); #1; lat++;
        end while (!out_valid && lat < 200);
        if (!out_valid) return;
        p = product;
        o = overflow;
        repeat (stall) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (product !== 32'h0) begin errors++; $display("FAIL reset_product: got %h expected 00000000", product); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        logic [15:0] va [4] = '{16'd524, 16'd60340, 16'hFFFF, 16'd0};
        logic [15:0] vb [4] = '{16'd5,   16'd60340, 16'd2,    16'hBEEF};
        logic [31:0] ep [4] = '{32'h00000A3C, 32'hD903F690, 32'h0001FFFE, 32'h0};
        logic        eo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] p;
        logic        o;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], 1'b0, 0, 0, p, o, lat);
            checks++; if (p !== ep[i]) begin errors++; $display("FAIL unsigned_product[%0d]: got %h expected %h", i, p, ep[i]); end
            checks++; if (o !== eo[i]) begin errors++; $display("FAIL unsigned_overflow[%0d]: got %b expected %b", i, o, eo[i]); end
            checks++; if (lat != 16) begin errors++; $display("FAIL unsigned_latency[%0d]: got %0d expected 16", i, lat); end
        end
    endtask

    task automatic test_signed();
        logic [15:0] va [5] = '{16'hFFFF, 16'h8000, 16'd7,        16'd0,    16'd300};
        logic [15:0] vb [5] = '{16'd2,    16'h8000, 16'hFFFD,     16'h8000, 16'hFED4};
        logic [31:0] ep [5] = '{32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFEB, 32'h0, 32'hFFFEA070};
        logic        eo [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] p;
        logic        o;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], 1'b1, 0, 0, p, o, lat);
            checks++; if (p !== ep[i]) begin errors++; $display("FAIL signed_product[%0d]: got %h expected %h", i, p, ep[i]); end
            checks++; if (o !== eo[i]) begin errors++; $display("FAIL signed_overflow[%0d]: got %b expected %b", i, o, eo[i]); end
            checks++; if (lat != 16) begin errors++; $display("FAIL signed_latency[%0d]: got %0d expected 16", i, lat); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        #1;
        in_valid = 1'b1; a = 16'd524; b = 16'd5; is_signed = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        checks++; if (!out_valid) begin errors++; $display("FAIL bp_out_valid_timeout: got %b expected 1", out_valid); end
        in_valid = 1'b1; a = 16'd3; b = 16'd3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== 32'h00000A3C) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got ov=%b ir=%b p=%h expected ov=1 ir=0 p=00000a3c", i, out_valid, in_ready, product);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got ov=%b ir=%b expected ov=0 ir=1", out_valid, in_ready); end
        @(posedge clk); #1;
        checks++; if (product !== 32'h00000A3C || in_ready !== 1'b1) begin errors++; $display("FAIL bp_retain: got p=%h ir=%b expected p=00000a3c ir=1", product, in_ready); end
    endtask

    task automatic test_async_reset();
        logic [31:0] p;
        logic        o;
        int          lat;
        int          seen;
        #1;
        in_valid = 1'b1; a = 16'd524; b = 16'd5; is_signed = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid: got %b expected 0", out_valid); end
        checks++; if (product !== 32'h0) begin errors++; $display("FAIL areset_product: got %h expected 00000000", product); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        checks++; if (seen != 0) begin errors++; $display("FAIL areset_no_result: got %0d valid cycles expected 0", seen); end
        run_op(16'd7, 16'd2620, 1'b0, 0, 0, p, o, lat);
        checks++; if (p !== 32'h000047A4) begin errors++; $display("FAIL areset_fresh_product: got %h expected 000047a4", p); end
        checks++; if (lat != 16) begin errors++; $display("FAIL areset_fresh_latency: got %0d expected 16", lat); end
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        int highs;
        first = -1; second = -1; highs = 0;
        #1;
        in_valid = 1'b1; a = 16'd3; b = 16'd5; is_signed = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                highs++;
                if (first < 0) first = i;
                else if (second < 0) second = i;
                checks++; if (product !== 32'd15) begin errors++; $display("FAIL b2b_product: got %h expected 0000000f", product); end
            end
        end
        in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++; if (first != 17) begin errors++; $display("FAIL b2b_first: got edge %0d expected 17", first); end
        checks++; if (second - first != WIDTH + 2) begin errors++; $display("FAIL b2b_period: got %0d expected %0d", second - first, WIDTH + 2); end
        checks++; if (highs != 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", highs); end
    endtask

    task automatic test_random();
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        logic [31:0] p;
        logic        o;
        int          lat;
        longint      pa;
        longint      pb;
        longint      pp;
        logic [31:0] ep;
        logic        eo;
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 17 == 0) ra = 16'h8000;
            if (i % 23 == 0) rb = 16'h0;
            rs = 1'($urandom_range(0, 1));
            if (rs) begin
                pa = longint'($signed(ra));
                pb = longint'($signed(rb));
            end else begin
                pa = longint'({48'd0, ra});
                pb = longint'({48'd0, rb});
            end
            pp = pa * pb;
            ep = pp[31:0];
            eo = rs ? (pp > 64'sd32767 || pp < -64'sd32768) : (pp > 64'sd65535);
            run_op(ra, rb, rs, $urandom_range(0, 3), $urandom_range(0, 4), p, o, lat);
            checks++; if (p !== ep) begin errors++; $display("FAIL rand_product[%0d]: a=%h b=%h s=%b got %h expected %h", i, ra, rb, rs, p, ep); end
            checks++; if (o !== eo) begin errors++; $display("FAIL rand_overflow[%0d]: a=%h b=%h s=%b got %b expected %b", i, ra, rb, rs, o, eo); end
            checks++; if (lat != 16) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected 16", i, lat); end
        end
    endtask

    // Absolute time bound so a stuck handshake can never hang the run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        reset     = 1'b1;
        #2;
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
